// File: rtl/trainer_pkg.sv
// Shared definitions for the trainer sequencer: gate indices, FSM states and
// the reference truth table of each gate.
package trainer_pkg;

  localparam logic [2:0] GATE_AND   = 3'd0;
  localparam logic [2:0] GATE_OR    = 3'd1;
  localparam logic [2:0] GATE_NOT_A = 3'd2;
  localparam logic [2:0] GATE_NAND  = 3'd3;
  localparam logic [2:0] GATE_NOR   = 3'd4;
  localparam logic [2:0] GATE_XOR   = 3'd5;
  localparam logic [2:0] GATE_XNOR  = 3'd6;
  localparam logic [2:0] GATE_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit i is the gate result for {a,b} = i, with a as the MSB.
  function automatic logic [3:0] expected_table(input logic [2:0] gate_sel);
    logic [3:0] t;
    case (gate_sel)
      GATE_AND:   t = 4'b1000;
      GATE_OR:    t = 4'b1110;
      GATE_NOT_A: t = 4'b0011;
      GATE_NAND:  t = 4'b0111;
      GATE_NOR:   t = 4'b0001;
      GATE_XOR:   t = 4'b0110;
      GATE_XNOR:  t = 4'b1001;
      default:    t = 4'b0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/trainer_sequencer_if.sv
// Board/core-side signal bundle of the trainer sequencer.
// Optional TRAINER_CHECK_EN adds the pass/fail_mask self-check outputs.
interface trainer_sequencer_if #(parameter int DWELL_W = 8);

  logic               start;
  logic               repeat_en;
  logic [2:0]         gate_sel;
  logic [DWELL_W-1:0] dwell;
  logic [6:0]         gate_out;
  logic               drive_a;
  logic               drive_b;
  logic               busy;
  logic               done;
  logic [3:0]         truth_table;
`ifdef TRAINER_CHECK_EN
  logic               pass;
  logic [3:0]         fail_mask;

  modport master (
    output start, repeat_en, gate_sel, dwell, gate_out,
    input  drive_a, drive_b, busy, done, truth_table, pass, fail_mask
  );
  modport slave (
    input  start, repeat_en, gate_sel, dwell, gate_out,
    output drive_a, drive_b, busy, done, truth_table, pass, fail_mask
  );
`else
  modport master (
    output start, repeat_en, gate_sel, dwell, gate_out,
    input  drive_a, drive_b, busy, done, truth_table
  );
  modport slave (
    input  start, repeat_en, gate_sel, dwell, gate_out,
    output drive_a, drive_b, busy, done, truth_table
  );
`endif

endinterface

// File: rtl/trainer_dwell_counter.sv
// Dwell counter: counts up from 0 and flags the last cycle of a combination
// (cnt == limit-1), then wraps to 0.
module trainer_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] limit_i,
  output logic               tc_o
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == (limit_i - ONE));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trainer_sequencer.sv
// Steps the trainer core through a,b = 00..11 and captures one gate's truth
// table. Optional TRAINER_CHECK_EN adds pass/fail_mask against the reference.
//
//   state | meaning
//   IDLE  | waiting for start, truth_table holds last result
//   RUN   | driving combination idx for dwell_eff cycles each
//   DONE  | one-cycle done pulse, then RUN (repeat_en) or IDLE
module trainer_sequencer
  import trainer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input logic               clk,
  input logic               rst,
  trainer_sequencer_if.slave bus
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [2:0]         sel_q, sel_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         tt_q, tt_d;
  logic [1:0]         drive_q, drive_d;
  logic               enter_run;
  logic               tc;
  logic [7:0]         gate_vec;

  // Reserved select lands on the padded zero bit.
  assign gate_vec = {1'b0, bus.gate_out};

  trainer_dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .load_i  (enter_run),
    .en_i    (state_q == RUN),
    .limit_i (dwell_q),
    .tc_o    (tc)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    dwell_d   = dwell_q;
    tt_d      = tt_q;
    enter_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          enter_run = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (tc) begin
          tt_d[idx_q] = gate_vec[sel_q];
          if (idx_q == 2'd3) state_d = DONE;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      DONE: begin
        if (bus.repeat_en) begin
          enter_run = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_run) begin
      sel_d   = bus.gate_sel;
      dwell_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
      idx_d   = 2'd0;
    end
    drive_d = (state_d == RUN) ? idx_d : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      sel_q   <= 3'd0;
      dwell_q <= '0;
      tt_q    <= 4'b0000;
      drive_q <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
      tt_q    <= tt_d;
      drive_q <= drive_d;
    end
  end

  assign bus.drive_a     = drive_q[1];
  assign bus.drive_b     = drive_q[0];
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.truth_table = tt_q;

`ifdef TRAINER_CHECK_EN
  logic       pass_q;
  logic [3:0] mask_q, mask_d;

  assign mask_d = tt_d ^ expected_table(sel_q);

  // Captured on the edge into DONE so the verdict is coincident with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
      mask_q <= 4'b0000;
    end else if (state_q == RUN && state_d == DONE) begin
      pass_q <= (mask_d == 4'b0000);
      mask_q <= mask_d;
    end
  end

  assign bus.pass      = pass_q;
  assign bus.fail_mask = mask_q;
`endif

endmodule

// File: tb/tb_trainer_sequencer.sv
// Scoreboard bench for trainer_sequencer: directed sweeps push expected
// results, a monitor checks them whenever done pulses.
module tb_trainer_sequencer;

  localparam int DWELL_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0] tt;
    logic       pass;
    logic [3:0] mask;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  trainer_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

  trainer_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the combinational trainer core, with a stuck-at-1 fault on AND.
  always_comb begin
    logic a, b;
    a = bus.drive_a;
    b = bus.drive_b;
    bus.gate_out = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    if (fault) bus.gate_out[0] = 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] tt, input logic p, input logic [3:0] m,
                      input int c);
    exp_t e;
    e.tt = tt; e.pass = p; e.mask = m; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy && !bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", int'(ok), 1);
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("truth_table", int'(bus.truth_table), int'(e.tt));
        chk("busy_in_done", int'(bus.busy), 0);
        chk("drive_in_done", int'({bus.drive_a, bus.drive_b}), 0);
`ifdef TRAINER_CHECK_EN
        chk("pass", int'(bus.pass), int'(e.pass));
        chk("fail_mask", int'(bus.fail_mask), int'(e.mask));
`endif
      end
    end
  end

  initial begin
    int c;
    bus.start = 1'b0;
    bus.repeat_en = 1'b0;
    bus.gate_sel = 3'd0;
    bus.dwell = 8'd0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_drives", int'({bus.drive_a, bus.drive_b}), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_tt", int'(bus.truth_table), 0);
`ifdef TRAINER_CHECK_EN
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_mask", int'(bus.fail_mask), 0);
`endif
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
    end

    // AND, dwell 3, single sweep, per-cycle drive checks
    c = cyc;
    bus.gate_sel = 3'd0; bus.dwell = 8'd3; bus.start = 1'b1;
    push(4'b1000, 1'b1, 4'b0000, c + 1 + 12);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      chk("and_drive", int'({bus.drive_a, bus.drive_b}), i / 3);
      chk("and_busy", int'(bus.busy), 1);
    end
    wait_idle();
    chk("tt_hold_idle", int'(bus.truth_table), 4'b1000);

    // XOR with dwell 0 behaves as dwell 1
    @(negedge clk);
    c = cyc;
    bus.gate_sel = 3'd5; bus.dwell = 8'd0; bus.start = 1'b1;
    push(4'b0110, 1'b1, 4'b0000, c + 1 + 4);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Repeat mode NOR dwell 2; gate_sel change applies to the next sweep
    @(negedge clk);
    c = cyc;
    bus.gate_sel = 3'd4; bus.dwell = 8'd2; bus.repeat_en = 1'b1; bus.start = 1'b1;
    push(4'b0001, 1'b1, 4'b0000, c + 1 + 8);
    push(4'b1001, 1'b1, 4'b0000, c + 1 + 8 + 9);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.gate_sel = 3'd6;
    repeat (8) @(negedge clk);
    bus.repeat_en = 1'b0;
    wait_idle();

    // Stuck-at-1 on AND output
    @(negedge clk);
    fault = 1'b1;
    c = cyc;
    bus.gate_sel = 3'd0; bus.dwell = 8'd1; bus.start = 1'b1;
    push(4'b1111, 1'b0, 4'b0111, c + 1 + 4);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    fault = 1'b0;

    // Reset during combination 2 aborts the sweep
    @(negedge clk);
    bus.gate_sel = 3'd0; bus.dwell = 8'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("abort_pre_drive", int'({bus.drive_a, bus.drive_b}), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_drives", int'({bus.drive_a, bus.drive_b}), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_tt", int'(bus.truth_table), 0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_stays_idle", int'(bus.busy), 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
